aes_inv_cipher_iter: RTL and testbench

Iterative AES inverse cipher: accepts one 128-bit ciphertext block plus the flat expanded key schedule and returns the plaintext after Nr round iterations, one round per clock. It is the decrypt-side counterpart of the encrypt datapath. It consumes the same flat key vector layout as the encrypt side, walking round keys from Nr down to 0. Valid/ready handshakes sit on both the input and output.

---
 rtl/aes_inv_cipher_iter.sv | 143 ++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, valid/ready handshakes on input and output.
// Optional macro AES_INV_KEY_CAPTURE_EN registers the key schedule on accept instead of reading it live.
module aes_inv_cipher_iter #(
    parameter int NK = 4,
    localparam int KW = 4*(NK+7)*32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  ciphertext,
    input  logic [KW-1:0] key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  plaintext,
    output logic          busy
);
    localparam int unsigned NR = NK + 6;

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_inv_cipher_iter: NK must be 4, 6 or 8");
    end

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t        state;
    logic [127:0]  st;
    logic [3:0]    rnd;
    logic [KW-1:0] key_use;
    logic [3:0]    rk_idx;
    logic [127:0]  rk, isr, isb, ark, imc;

    function automatic logic [7:0] inv_sb(input logic [7:0] b);
        return INV_SBOX[8*(255-int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        for (int unsigned i = 0; i < 4; i++) begin
            a   = c[31-8*i -: 8];
            x2  = xt(a);
            x4  = xt(x2);
            x8  = xt(x4);
            m9[i]  = x8 ^ a;
            m11[i] = x8 ^ x2 ^ a;
            m13[i] = x8 ^ x4 ^ a;
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

`ifdef AES_INV_KEY_CAPTURE_EN
    logic [KW-1:0] key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            key_q <= '0;
        else if (state == IDLE && in_valid)
            key_q <= key;
    end

    // The accept edge itself still needs rk[Nr] from the live input.
    assign key_use = (state == IDLE) ? key : key_q;
`else
    assign key_use = key;
`endif

    always_comb begin
        rk_idx = (state == IDLE) ? 4'(NR) : rnd;
        rk  = '0;
        isr = '0;
        isb = '0;
        imc = '0;
        for (int unsigned r = 0; r <= NR; r++)
            if (rk_idx == 4'(r))
                rk = key_use[KW-1-128*r -: 128];
        // Row k%4 rotates right: output column c takes source column (c - row) mod 4.
        for (int unsigned k = 0; k < 16; k++)
            isr[127-8*k -: 8] = st[127-8*(k%4 + 4*((k/4 + 4 - k%4) % 4)) -: 8];
        for (int unsigned k = 0; k < 16; k++)
            isb[127-8*k -: 8] = inv_sb(isr[127-8*k -: 8]);
        ark = isb ^ rk;
        for (int unsigned c = 0; c < 4; c++)
            imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            st    <= '0;
            rnd   <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    st    <= ciphertext ^ rk;
                    rnd   <= 4'(NR - 1);
                    state <= ROUND;
                end
                ROUND: begin
                    st  <= imc;
                    rnd <= rnd - 4'd1;
                    if (rnd == 4'd1)
                        state <= FINAL;
                end
                FINAL: begin
                    st    <= ark;
                    state <= DONE;
                end
                DONE: if (out_ready)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign plaintext = st;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 vectors on NK=4/6/8 instances, random blocks
// checked against a forward-cipher reference model, plus backpressure/back-to-back/reset sequences.
module tb_aes_inv_cipher_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic         iv [3];
    logic         ir [3];
    logic         ov [3];
    logic         ordy [3];
    logic         bz [3];
    logic [127:0] ct [3];
    logic [127:0] pt [3];
    logic [1919:0] kb [3];

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_t [256];

    always #5 clk = ~clk;

    aes_inv_cipher_iter #(.NK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .ciphertext(ct[0]),
        .key(kb[0][1919 -: 1408]), .out_valid(ov[0]), .out_ready(ordy[0]), .plaintext(pt[0]), .busy(bz[0]));
    aes_inv_cipher_iter #(.NK(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .ciphertext(ct[1]),
        .key(kb[1][1919 -: 1664]), .out_valid(ov[1]), .out_ready(ordy[1]), .plaintext(pt[1]), .busy(bz[1]));
    aes_inv_cipher_iter #(.NK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .ciphertext(ct[2]),
        .key(kb[2][1919 -: 1920]), .out_valid(ov[2]), .out_ready(ordy[2]), .plaintext(pt[2]), .busy(bz[2]));

    // ---------------- reference model (forward cipher, plain GF arithmetic) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b};
        return t[15-n -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        logic [31:0] r;
        for (int j = 0; j < 4; j++)
            r[31-8*j -: 8] = sb_t[w[31-8*j -: 8]];
        return r;
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] k, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc;
        logic [1919:0] big;
        big = '0;
        rc = 8'h01;
        for (int i = 0; i < 4*(nk+7); i++) begin
            if (i < nk) w[i] = k[255-32*i -: 32];
            else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) t = subw(t);
                w[i] = w[i-nk] ^ t;
            end
            big[1919-32*i -: 32] = w[i];
        end
        return big;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [1919:0] big, input int nk);
        logic [7:0] s [16];
        logic [7:0] u [16];
        logic [127:0] r;
        int nr;
        nr = nk + 6;
        for (int k = 0; k < 16; k++) s[k] = p[127-8*k -: 8] ^ big[1919-8*k -: 8];
        for (int rr = 1; rr <= nr; rr++) begin
            for (int k = 0; k < 16; k++) u[k] = sb_t[s[(k%4) + 4*(((k/4) + (k%4)) % 4)]];
            if (rr < nr) begin
                for (int c = 0; c < 4; c++)
                    for (int i = 0; i < 4; i++)
                        s[4*c+i] = gmul(8'h02, u[4*c+i]) ^ gmul(8'h03, u[4*c+(i+1)%4])
                                   ^ u[4*c+(i+2)%4] ^ u[4*c+(i+3)%4];
            end else s = u;
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ big[1919-128*rr-8*k -: 8];
        end
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[k];
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_block(input int d, input logic [255:0] k, input logic [127:0] cin,
                             input logic [127:0] pexp, input bit zero_key, input bit expect_ok,
                             input string name);
        int n;
        kb[d] = expand(k, 4 + 2*d);
        ct[d] = cin;
        ordy[d] = 1'b1;
        iv[d] = 1'b1;
        chk({name, " in_ready"}, 128'(ir[d]), 128'd1);
        tick();
        iv[d] = 1'b0;
        if (zero_key) kb[d] = '0;
        n = 0;
        while (!ov[d] && n < 40) begin
            tick();
            n++;
        end
        chk({name, " latency"}, 128'(n), 128'(10 + 2*d));
        if (expect_ok) chk({name, " plaintext"}, pt[d], pexp);
        else begin
            checks++;
            if (pt[d] === pexp) begin
                errors++;
                $display("FAIL %s live-key: got %h required any value other than %h", name, pt[d], pexp);
            end
        end
        tick();
        chk({name, " post ov/ir"}, 128'({ov[d], ir[d]}), 128'(2'b01));
    endtask

    typedef struct {
        int           d;
        logic [255:0] k;
        logic [127:0] c;
        logic [127:0] p;
    } vec_t;

    vec_t vt [4];
    localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acc2, nout;
        logic prev_bz;
        logic [127:0] rp, rc2;
        logic [255:0] rk;
        logic [1919:0] big;

        for (int a = 0; a < 256; a++) begin
            logic [7:0] b;
            b = 8'h01;
            for (int i = 0; i < 254; i++) b = gmul(b, 8'(a));
            sb_t[a] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end

        vt[0] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                  128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
        vt[1] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_C};
        vt[2] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                  128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_C};
        vt[3] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h8ea2b7ca516745bfeafc49904b496089, PT_C};

        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; ct[d] = '0; kb[d] = '0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset ctl dut%0d", d), 128'({ir[d], ov[d], bz[d]}), 128'(3'b100));
            chk($sformatf("reset pt dut%0d", d), pt[d], 128'h0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++)
            run_block(vt[i].d, vt[i].k, vt[i].c, vt[i].p, 1'b0, 1'b1, $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            int d;
            d = i % 3;
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            big = expand(rk, 4 + 2*d);
            rc2 = encrypt(rp, big, 4 + 2*d);
            run_block(d, rk, rc2, rp, 1'b0, 1'b1, $sformatf("rand%0d", i));
        end

`ifdef AES_INV_KEY_CAPTURE_EN
        run_block(0, vt[1].k, vt[1].c, vt[1].p, 1'b1, 1'b1, "keycap");
`else
        run_block(0, vt[1].k, vt[1].c, vt[1].p, 1'b1, 1'b0, "keylive");
`endif

        // backpressure: hold out_ready low, pulse in_valid, result must hold
        kb[0] = expand(vt[0].k, 4);
        ct[0] = vt[0].c;
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 40) begin
            tick();
            n++;
        end
        chk("bp latency", 128'(n), 128'd10);
        for (int i = 0; i < 20; i++) begin
            iv[0] = i[0];
            ct[0] = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk($sformatf("bp hold ctl %0d", i), 128'({ov[0], ir[0], bz[0]}), 128'(3'b101));
            chk($sformatf("bp hold pt %0d", i), pt[0], vt[0].p);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        chk("bp release", 128'({ov[0], ir[0], bz[0]}), 128'(3'b010));
        tick();
        chk("bp single handshake", 128'({ov[0], ir[0], bz[0]}), 128'(3'b010));

        // back-to-back: in_valid held high, out_ready high
        kb[0] = expand(vt[1].k, 4);
        ct[0] = vt[1].c;
        ordy[0] = 1'b1;
        iv[0] = 1'b1;
        tick();
        acc2 = -1;
        nout = 0;
        prev_bz = bz[0];
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (ov[0]) begin
                nout++;
                chk($sformatf("b2b pt out%0d", nout), pt[0], PT_C);
            end
            if (bz[0] && !prev_bz && acc2 < 0) begin
                acc2 = i;
                iv[0] = 1'b0;
            end
            prev_bz = bz[0];
        end
        iv[0] = 1'b0;
        chk("b2b second accept", 128'(acc2), 128'd12);
        chk("b2b output count", 128'(nout), 128'd2);

        // reset in the middle of round processing
        kb[0] = expand(vt[0].k, 4);
        ct[0] = vt[0].c;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("midreset ctl", 128'({ov[0], ir[0], bz[0]}), 128'(3'b010));
        chk("midreset pt", pt[0], 128'h0);
        tick();
        rst_n = 1'b1;
        tick();
        run_block(0, vt[0].k, vt[0].c, vt[0].p, 1'b0, 1'b1, "after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
